// File: rtl/sipo_rx_ctrl_if.sv
`default_nettype none
//==============================================================================
// sipo_rx_ctrl_if - serial-in / parallel-out handshake bundle for sipo_rx_ctrl
// rev 1.0
//==============================================================================
interface sipo_rx_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             din;
   logic             din_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             busy;
   logic             overrun;
   logic             parity_err;

   modport master (
      output start, din, din_valid, out_ready,
      input  dout, dout_valid, busy, overrun, parity_err
   );

   modport slave (
      input  start, din, din_valid, out_ready,
      output dout, dout_valid, busy, overrun, parity_err
   );
endinterface
`default_nettype wire

// File: rtl/sipo_rx_ctrl.sv
`default_nettype none
//==============================================================================
// sipo_rx_ctrl - frames LSB-first serial bits into WIDTH-bit words, valid/ready out
// option macro PARITY_CHK_EN: one trailing even-parity bit per frame | rev 1.0
//==============================================================================
module sipo_rx_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   sipo_rx_ctrl_if.slave bus
);
`ifdef PARITY_CHK_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   // The final bit of a frame never needs storing, so the register holds one bit less.
   localparam int SW = FRAME - 1;
   localparam int CW = $clog2(FRAME + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [SW-1:0]    shreg, shreg_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [WIDTH-1:0] dout_q, dout_nx;
   logic             overrun_q, overrun_nx;
   logic             last_bit;
`ifdef PARITY_CHK_EN
   logic             perr_q, perr_nx;
`endif

   assign last_bit = (cnt == CW'(FRAME - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         dout_q    <= '0;
         overrun_q <= 1'b0;
`ifdef PARITY_CHK_EN
         perr_q    <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         shreg     <= shreg_nx;
         cnt       <= cnt_nx;
         dout_q    <= dout_nx;
         overrun_q <= overrun_nx;
`ifdef PARITY_CHK_EN
         perr_q    <= perr_nx;
`endif
      end
   end

   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      cnt_nx     = cnt;
      dout_nx    = dout_q;
      overrun_nx = overrun_q;
`ifdef PARITY_CHK_EN
      perr_nx    = perr_q;
`endif
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nx   = SHIFT;
               shreg_nx   = '0;
               cnt_nx     = '0;
               overrun_nx = 1'b0;
            end
         end
         SHIFT: begin
            if (bus.start) begin
               shreg_nx   = '0;
               cnt_nx     = '0;
               overrun_nx = 1'b0;
            end else if (bus.din_valid) begin
               cnt_nx = cnt + CW'(1);
               if (last_bit) begin
                  state_nx = DONE;
`ifdef PARITY_CHK_EN
                  dout_nx  = shreg;
                  perr_nx  = ^{shreg, bus.din};
`else
                  dout_nx  = {bus.din, shreg};
`endif
               end else begin
                  shreg_nx = SW'({bus.din, shreg} >> 1);
               end
            end
         end
         DONE: begin
            if (bus.din_valid) begin
               overrun_nx = 1'b1;
            end
            if (bus.out_ready) begin
               state_nx = IDLE;
`ifdef PARITY_CHK_EN
               perr_nx  = 1'b0;
`endif
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = (state == DONE);
   assign bus.busy       = (state == SHIFT);
   assign bus.overrun    = overrun_q;
`ifdef PARITY_CHK_EN
   assign bus.parity_err = perr_q;
`else
   assign bus.parity_err = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_sipo_rx_ctrl.sv
`default_nettype none
//==============================================================================
// tb_sipo_rx_ctrl - directed self-checking bench with a queue-based frame model
// rev 1.0
//==============================================================================
module tb_sipo_rx_ctrl;
   localparam int WIDTH = 4;
`ifdef PARITY_CHK_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   bit   chk_en;

   sipo_rx_ctrl_if #(.WIDTH(WIDTH)) bus ();

   sipo_rx_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: a frame is a list of accepted bits; a word is held until consumed.
   bit             m_open;
   bit             m_hold;
   bit [WIDTH-1:0] m_dout;
   bit             m_ovr;
   bit             m_perr;
   bit             m_bits[$];

   always @(posedge clk) begin
      if (!rst_n) begin
         m_open = 0; m_hold = 0; m_dout = '0; m_ovr = 0; m_perr = 0;
         m_bits.delete();
      end else if (m_hold) begin
         if (bus.din_valid) m_ovr = 1;
         if (bus.out_ready) begin
            m_hold = 0;
            m_perr = 0;
         end
      end else if (bus.start) begin
         m_open = 1;
         m_ovr  = 0;
         m_bits.delete();
      end else if (m_open && bus.din_valid) begin
         m_bits.push_back(bus.din);
         if (m_bits.size() == FRAME) begin
            for (int i = 0; i < WIDTH; i++) m_dout[i] = m_bits[i];
`ifdef PARITY_CHK_EN
            m_perr = 0;
            foreach (m_bits[i]) m_perr ^= m_bits[i];
`endif
            m_open = 0;
            m_hold = 1;
         end
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("m_dout",       32'(bus.dout),       32'(m_dout));
         cmp("m_dout_valid", 32'(bus.dout_valid), 32'(m_hold));
         cmp("m_busy",       32'(bus.busy),       32'(m_open));
         cmp("m_overrun",    32'(bus.overrun),    32'(m_ovr));
         cmp("m_parity_err", 32'(bus.parity_err), 32'(m_perr));
      end
   end

   task automatic cyc(input logic s, input logic v, input logic d, input logic r);
      bus.start = s; bus.din_valid = v; bus.din = d; bus.out_ready = r;
      @(negedge clk);
   endtask

   // Sends the word in line order (v[0] first), then the parity bit if enabled.
   task automatic send_frame(input logic [WIDTH-1:0] v, input logic p, input int gap,
                             input logic r);
      logic b;
      for (int i = 0; i < FRAME; i++) begin
         if (i < WIDTH) b = v[i];
         else           b = p;
         cyc(1'b0, 1'b1, b, r);
         if (i != FRAME - 1) repeat (gap) cyc(1'b0, 1'b0, 1'b0, r);
      end
   endtask

   initial begin
      tests = 0; fails = 0; chk_en = 0;
      rst_n = 1'b0;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk_en = 1;
      cmp("rst_dout", 32'(bus.dout), 32'h0);
      cmp("rst_busy", 32'(bus.busy), 32'h0);
      cmp("rst_valid", 32'(bus.dout_valid), 32'h0);
      rst_n = 1'b1;

      // Back-to-back bits, consumer always ready
      cyc(1, 0, 0, 1);
      cmp("t1_busy", 32'(bus.busy), 32'h1);
      send_frame(4'b1101, 1'b1, 0, 1'b1);
      cmp("t1_valid", 32'(bus.dout_valid), 32'h1);
      cmp("t1_dout", 32'(bus.dout), 32'hD);
      cmp("t1_busy_end", 32'(bus.busy), 32'h0);
      cmp("t1_perr", 32'(bus.parity_err), 32'h0);
      cyc(0, 0, 0, 1);
      cmp("t1_valid_drop", 32'(bus.dout_valid), 32'h0);
      cmp("t1_dout_hold", 32'(bus.dout), 32'hD);

      // Three idle cycles between bits
      cyc(1, 0, 0, 1);
      send_frame(4'b1101, 1'b1, 3, 1'b1);
      cmp("t2_dout", 32'(bus.dout), 32'hD);
      cmp("t2_valid", 32'(bus.dout_valid), 32'h1);
      cyc(0, 0, 0, 1);

      // Held word, bits arriving while full, start during handshake ignored
      cyc(1, 0, 0, 0);
      send_frame(4'b0110, 1'b0, 0, 1'b0);
      cyc(0, 1, 1, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cmp("t3_dout", 32'(bus.dout), 32'h6);
      cmp("t3_valid", 32'(bus.dout_valid), 32'h1);
      cmp("t3_overrun", 32'(bus.overrun), 32'h1);
      cyc(1, 0, 0, 1);
      cmp("t3_hs_valid", 32'(bus.dout_valid), 32'h0);
      cmp("t3_hs_busy", 32'(bus.busy), 32'h0);
      cmp("t3_ovr_sticky", 32'(bus.overrun), 32'h1);
      cyc(1, 0, 0, 0);
      cmp("t3_start_busy", 32'(bus.busy), 32'h1);
      cmp("t3_ovr_clr", 32'(bus.overrun), 32'h0);

      // Restart mid-frame, simultaneous bit dropped
      cyc(0, 1, 1, 0);
      cyc(0, 1, 1, 0);
      cyc(1, 1, 1, 1);
      send_frame(4'b0100, 1'b1, 0, 1'b1);
      cmp("t4_dout", 32'(bus.dout), 32'h4);
      cmp("t4_ovr", 32'(bus.overrun), 32'h0);
      cyc(0, 0, 0, 1);

      // Reset mid-frame discards the partial word
      cyc(1, 0, 0, 1);
      cyc(0, 1, 1, 1);
      cyc(0, 1, 1, 1);
      cyc(0, 1, 1, 1);
      rst_n = 1'b0;
      cyc(0, 0, 0, 1);
      rst_n = 1'b1;
      cmp("t5_rst_dout", 32'(bus.dout), 32'h0);
      cmp("t5_rst_busy", 32'(bus.busy), 32'h0);
      cyc(0, 1, 1, 1);
      cyc(0, 0, 0, 1);
      cmp("t5_no_valid", 32'(bus.dout_valid), 32'h0);
      cyc(1, 0, 0, 1);
      send_frame(4'b1111, 1'b0, 0, 1'b1);
      cmp("t5_dout", 32'(bus.dout), 32'hF);
      cyc(0, 0, 0, 1);

      // Bit coinciding with start in IDLE is not captured
      cyc(1, 1, 1, 1);
      send_frame(4'b0000, 1'b0, 0, 1'b1);
      cmp("t6_dout", 32'(bus.dout), 32'h0);
      cmp("t6_valid", 32'(bus.dout_valid), 32'h1);
      cmp("t6_ovr", 32'(bus.overrun), 32'h0);
      cyc(0, 0, 0, 1);

`ifdef PARITY_CHK_EN
      cyc(1, 0, 0, 0);
      send_frame(4'b1101, 1'b0, 0, 1'b0);
      cmp("t7_dout", 32'(bus.dout), 32'hD);
      cmp("t7_perr", 32'(bus.parity_err), 32'h1);
      cyc(0, 0, 0, 1);
      cmp("t7_perr_clr", 32'(bus.parity_err), 32'h0);
      cyc(1, 0, 0, 1);
      send_frame(4'b1101, 1'b1, 0, 1'b1);
      cmp("t7_perr_ok", 32'(bus.parity_err), 32'h0);
      cyc(0, 0, 0, 1);
`endif

      cyc(0, 0, 0, 0);
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
